// File: rtl/l1i_cache_pkg.sv
// core_l1i_pkg: shared FSM encoding and address-field widths for the L1 instruction cache
package core_l1i_pkg;

   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tag_w(input int sets, input int line_words);
      return 30 - $clog2(sets) - $clog2(line_words);
   endfunction

endpackage

// File: rtl/l1i_cache_if.sv
// l1i_cache_if: fetch-side lookup and memory refill signals of the instruction cache
interface l1i_cache_if;

   logic [31:0] l1i_addr_in;
   logic        l1i_val_in;
   logic        l1i_flush_in;
   logic [31:0] l1i_inst_out;
   logic        l1i_ack_out;
   logic        l1i_stall_out;
   logic        mem_req_val_out;
   logic [31:0] mem_req_addr_out;
   logic        mem_req_rdy_in;
   logic        mem_rsp_val_in;
   logic [31:0] mem_rsp_data_in;

   modport slave (
      input  l1i_addr_in, l1i_val_in, l1i_flush_in, mem_req_rdy_in, mem_rsp_val_in, mem_rsp_data_in,
      output l1i_inst_out, l1i_ack_out, l1i_stall_out, mem_req_val_out, mem_req_addr_out
   );

   modport master (
      output l1i_addr_in, l1i_val_in, l1i_flush_in, mem_req_rdy_in, mem_rsp_val_in, mem_rsp_data_in,
      input  l1i_inst_out, l1i_ack_out, l1i_stall_out, mem_req_val_out, mem_req_addr_out
   );

endinterface

// File: rtl/l1i_tag_array.sv
// l1i_tag_array: per-line valid bits and tags with combinational lookup, refill write and flush-clear
module l1i_tag_array import core_l1i_pkg::*; #(
   parameter int SETS  = 16,
   parameter int TAG_W = 24,
   localparam int IW   = idx_w(SETS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IW-1:0]    rd_idx,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             hit,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             flush
);

   logic [SETS-1:0]  valid;
   logic [TAG_W-1:0] tags [SETS];

   assign hit = valid[rd_idx] && tags[rd_idx] == rd_tag;

   // valid bits: flush beats a same-cycle refill completion
   always_ff @(posedge clk) begin
      if (rst || flush) valid <= '0;
      else if (wr_en) valid[wr_idx] <= 1'b1;
   end

   // tags are not reset; a line only counts once its valid bit is set
   always_ff @(posedge clk) begin
      if (wr_en) tags[wr_idx] <= wr_tag;
   end

endmodule

// File: rtl/l1i_cache.sv
// l1i_cache: direct-mapped read-only instruction cache with whole-line refill on miss
module l1i_cache import core_l1i_pkg::*; #(
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input logic       clk,
   input logic       rst,
   l1i_cache_if.slave bus
);

   localparam int OW = off_w(LINE_WORDS);
   localparam int IW = idx_w(SETS);
   localparam int TW = tag_w(SETS, LINE_WORDS);

   state_t        state, nxt;
   logic [TW-1:0] tag, l_tag;
   logic [IW-1:0] idx, l_idx;
   logic [OW-1:0] off, cnt;
   logic          hit, last, flushed, wr_en;
   logic [31:0]   data [SETS][LINE_WORDS];
   logic          unused;

   assign off    = bus.l1i_addr_in[OW+1:2];
   assign idx    = bus.l1i_addr_in[OW+IW+1:OW+2];
   assign tag    = bus.l1i_addr_in[31:OW+IW+2];
   assign unused = &{1'b0, bus.l1i_addr_in[1:0]};
   assign last   = cnt == OW'(LINE_WORDS - 1);
   assign wr_en  = state == FILL && bus.mem_rsp_val_in && last && !flushed;

   l1i_tag_array #(.SETS(SETS), .TAG_W(TW)) u_tags (
      .clk    (clk),
      .rst    (rst),
      .rd_idx (idx),
      .rd_tag (tag),
      .hit    (hit),
      .wr_en  (wr_en),
      .wr_idx (l_idx),
      .wr_tag (l_tag),
      .flush  (bus.l1i_flush_in)
   );

   // next state and outputs; everything is held at zero while reset is asserted
   always_comb begin
      nxt                  = state;
      bus.l1i_ack_out      = 1'b0;
      bus.l1i_inst_out     = '0;
      bus.l1i_stall_out    = 1'b0;
      bus.mem_req_val_out  = 1'b0;
      bus.mem_req_addr_out = '0;
      if (!rst) begin
         case (state)
            IDLE: if (bus.l1i_val_in) begin
               bus.l1i_ack_out   = hit;
               bus.l1i_inst_out  = hit ? data[idx][off] : '0;
               bus.l1i_stall_out = !hit;
               nxt               = hit ? IDLE : REQ;
            end
            REQ: begin
               bus.l1i_stall_out    = 1'b1;
               bus.mem_req_val_out  = 1'b1;
               bus.mem_req_addr_out = {l_tag, l_idx, {(OW+2){1'b0}}};
               nxt                  = bus.mem_req_rdy_in ? FILL : REQ;
            end
            FILL: begin
               bus.l1i_stall_out = 1'b1;
               nxt               = (bus.mem_rsp_val_in && last) ? IDLE : FILL;
            end
            default: nxt = IDLE;
         endcase
      end
   end

   // state, beat counter and the sticky flush-during-refill flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         flushed <= 1'b0;
      end else begin
         state   <= nxt;
         flushed <= state != IDLE && nxt != IDLE && (flushed || bus.l1i_flush_in);
         if (state == REQ && bus.mem_req_rdy_in) cnt <= '0;
         else if (state == FILL && bus.mem_rsp_val_in) cnt <= cnt + 1'b1;
      end
   end

   // latch the missing line so the fetch stage may move its PC during the refill
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.l1i_val_in && !hit) begin
         l_tag <= tag;
         l_idx <= idx;
      end
   end

   // refill beats land in the latched line, word 0 first
   always_ff @(posedge clk) begin
      if (!rst && state == FILL && bus.mem_rsp_val_in) data[l_idx][cnt] <= bus.mem_rsp_data_in;
   end

endmodule

// File: tb/tb_l1i_cache.sv
// tb_l1i_cache: scoreboard bench for l1i_cache against a line-residency reference model
module tb_l1i_cache;

   localparam int LW = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] inst;
      bit          hit;
      int          c;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0, bad = 0, cyc = 0;

   sb_t         sbq[$];
   logic [31:0] reqq[$];
   bit [15:0]   mv;
   logic [27:0] ml [16];

   int          rdy_pct = 100, gmax = 0;
   bit          stray = 0, busy = 0;
   int          beat = 0, gap = 0;
   logic [31:0] line_a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   l1i_cache_if bus();

   l1i_cache #(.SETS(16), .LINE_WORDS(LW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] memfn(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      return (w[31:4] == 28'h10) ? 32'hA0 + {28'h0, w[3:2]} : (w * 32'h9E3779B1) ^ 32'h00C0FFEE;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", n, act, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a, input int fk, output int lat);
      logic [27:0] ln;
      logic [3:0]  ix;
      bit          h;
      ln = a[31:4];
      ix = a[7:4];
      h  = mv[ix] && ml[ix] == ln;
      if (h && fk > 0) fk = -1;
      if (fk == 0) mv = '0;
      if (!h) begin
         mv[ix] = 1'b1;
         ml[ix] = ln;
         reqq.push_back({ln, 4'h0});
      end
      if (fk > 0) begin
         mv     = '0;
         mv[ix] = 1'b1;
         ml[ix] = ln;
         reqq.push_back({ln, 4'h0});
      end
      @(posedge clk);
      #1;
      bus.l1i_addr_in  = a;
      bus.l1i_val_in   = 1'b1;
      bus.l1i_flush_in = (fk == 0);
      sbq.push_back('{a, memfn(a), h, cyc});
      lat = 0;
      forever begin
         @(negedge clk);
         if (bus.l1i_ack_out) break;
         chk("stall_while_wait", {31'h0, bus.l1i_stall_out}, 32'h1);
         if (lat >= 400) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout: addr %h got no ack within 400 cycles", a);
            sbq.delete();
            break;
         end
         @(posedge clk);
         #1;
         lat++;
         bus.l1i_flush_in = (fk > 0 && lat == fk);
      end
   endtask

   task automatic bubble();
      @(posedge clk);
      #1;
      bus.l1i_val_in   = 1'b0;
      bus.l1i_flush_in = 1'b0;
      bus.l1i_addr_in  = $urandom;
      @(negedge clk);
      chk("idle_ack", {31'h0, bus.l1i_ack_out}, 32'h0);
      chk("idle_inst", bus.l1i_inst_out, 32'h0);
      chk("idle_stall", {31'h0, bus.l1i_stall_out}, 32'h0);
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_ack"}, {31'h0, bus.l1i_ack_out}, 32'h0);
      chk({n, "_stall"}, {31'h0, bus.l1i_stall_out}, 32'h0);
      chk({n, "_req"}, {31'h0, bus.mem_req_val_out}, 32'h0);
      chk({n, "_inst"}, bus.l1i_inst_out, 32'h0);
      chk({n, "_addr"}, bus.mem_req_addr_out, 32'h0);
   endtask

   // monitor: every ack pops the oldest outstanding lookup
   initial begin
      sb_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.l1i_ack_out) begin
            chk("ack_stall_excl", {31'h0, bus.l1i_stall_out}, 32'h0);
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_ack: inst %h with nothing outstanding", bus.l1i_inst_out);
            end else begin
               e = sbq.pop_front();
               chk("inst", bus.l1i_inst_out, e.inst);
               chk("hit_timing", {31'h0, cyc == e.c}, {31'h0, e.hit});
            end
         end
      end
   end

   // memory: accepts requests, returns beats with random gaps, emits stray beats when idle
   initial begin
      logic [31:0] pa;
      bit          pv;
      pv                  = 0;
      pa                  = '0;
      bus.mem_req_rdy_in  = 1'b0;
      bus.mem_rsp_val_in  = 1'b0;
      bus.mem_rsp_data_in = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rsp_val_in = 1'b0;
         bus.mem_req_rdy_in = 1'b0;
         if (busy) begin
            if (gap > 0) gap--;
            else begin
               bus.mem_rsp_val_in  = 1'b1;
               bus.mem_rsp_data_in = memfn(line_a + 32'(4 * beat));
               beat++;
               busy = beat < LW;
               gap  = $urandom_range(0, gmax);
            end
         end else begin
            bus.mem_rsp_val_in  = stray && ($urandom_range(0, 7) == 0);
            bus.mem_rsp_data_in = 32'hDEAD0000 ^ $urandom;
            bus.mem_req_rdy_in  = int'($urandom_range(0, 99)) < rdy_pct;
         end
         @(negedge clk);
         if (!rst && bus.mem_req_val_out) begin
            if (pv) chk("req_addr_stable", bus.mem_req_addr_out, pa);
            if (bus.mem_req_rdy_in) begin
               if (reqq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_req: addr %h with no miss outstanding", bus.mem_req_addr_out);
               end else chk("req_addr", bus.mem_req_addr_out, reqq.pop_front());
               busy   = 1;
               beat   = 0;
               line_a = bus.mem_req_addr_out;
               gap    = $urandom_range(0, gmax);
               pv     = 0;
            end else begin
               pv = 1;
               pa = bus.mem_req_addr_out;
            end
         end else pv = 0;
      end
   end

   // stimulus: directed scenarios first, then randomized traffic with backpressure and flushes
   initial begin
      int lat, fk;
      logic [31:0] a;
      mv               = '0;
      bus.l1i_addr_in  = 32'h104;
      bus.l1i_val_in   = 1'b1;
      bus.l1i_flush_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk_zero("reset");
      end
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.l1i_val_in = 1'b0;

      fetch(32'h104, -1, lat);
      chk("cold_miss_lat", lat, 6);
      for (int i = 0; i < 4; i++) begin
         fetch(32'h100 + 32'(4 * i), -1, lat);
         chk("b2b_hit_lat", lat, 0);
      end
      bubble();
      fetch(32'h1100, -1, lat);
      chk("evict_lat", lat, 6);
      fetch(32'h100, -1, lat);
      chk("evicted_miss_lat", lat, 6);
      fetch(32'h104, 0, lat);
      chk("flush_hit_lat", lat, 0);
      fetch(32'h100, 3, lat);
      chk("flush_fill_lat", lat, 12);
      fetch(32'h108, -1, lat);
      chk("refilled_hit_lat", lat, 0);

      reqq.push_back(32'h300);
      @(posedge clk);
      #1;
      bus.l1i_addr_in = 32'h300;
      for (int i = 0; i < 50 && !(busy && beat >= 2); i++) @(negedge clk);
      chk("fill_reached", {31'h0, busy && beat >= 2}, 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk_zero("fill_reset");
      @(posedge clk);
      #1;
      rst            = 1'b0;
      bus.l1i_val_in = 1'b0;
      mv             = '0;
      fetch(32'h100, -1, lat);
      chk("post_reset_miss_lat", lat, 6);

      rdy_pct = 50;
      gmax    = 2;
      stray   = 1;
      for (int n = 0; n < 300; n++) begin
         a  = ($urandom_range(0, 3) << 8) | ($urandom & 32'hFF);
         fk = $urandom_range(0, 9);
         fk = (fk == 0) ? 0 : (fk == 1) ? int'($urandom_range(1, 1 + LW)) : -1;
         fetch(a, fk, lat);
         if ($urandom_range(0, 4) == 0) bubble();
      end

      @(posedge clk);
      #1;
      bus.l1i_val_in   = 1'b0;
      bus.l1i_flush_in = 1'b0;
      repeat (10) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);
      chk("req_drained", reqq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
